// File: rtl/mem_core_timed_if.sv
// Bus interface for mem_core_timed: cycle request, write data, read data
// and status flags. clk and reset_n stay plain ports on the core.
interface mem_core_timed_if #(
   parameter int AW = 15,
   parameter int DW = 12
);
   logic          mem_start;
   logic          wr_mode;
   logic [AW-1:0] addr;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          strobe_n;
   logic          mem_done_n;
   logic          busy;
   logic [DW-1:0] tap0;
   logic [DW-1:0] tap1;
   logic          parity_err;

   modport master (
      output mem_start, wr_mode, addr, data_in,
      input  data_out, strobe_n, mem_done_n, busy, tap0, tap1, parity_err
   );

   modport slave (
      input  mem_start, wr_mode, addr, data_in,
      output data_out, strobe_n, mem_done_n, busy, tap0, tap1, parity_err
   );
endinterface

// File: rtl/mem_core_timed.sv
// mem_core_timed: timer-sequenced word memory modelled on a core-memory
// cycle. A start edge launches a fixed-length cycle: the word is read at
// READ_TICK, a sense strobe pulses, the word (or new data) is written back
// at WRITE_TICK, and the cycle parks in a done state at DONE_TICK.
// Optional feature macro: MEM_PARITY_EN adds one odd-parity bit per word,
// checked on every read and reported through a sticky parity_err flag.
module mem_core_timed #(
   parameter int AW           = 15,
   parameter int DW           = 12,
   parameter int READ_TICK    = 30,
   parameter int STROBE_START = 50,
   parameter int STROBE_LEN   = 10,
   parameter int WRITE_TICK   = 80,
   parameter int DONE_TICK    = 149,
   parameter int TAP0_ADDR    = 'o7754,
   parameter int TAP1_ADDR    = 'o7755
) (
   input logic             clk,
   input logic             reset_n,
   mem_core_timed_if.slave bus
);

`ifdef MEM_PARITY_EN
   localparam int MW = DW + 1;   // data plus stored parity bit in the MSB
`else
   localparam int MW = DW;
`endif

   localparam int DEPTH = 2 ** AW;

   localparam logic [7:0] L_READ       = 8'(READ_TICK);
   localparam logic [7:0] L_STROBE_BEG = 8'(STROBE_START);
   localparam logic [7:0] L_STROBE_END = 8'(STROBE_START + STROBE_LEN);
   localparam logic [7:0] L_WRITE      = 8'(WRITE_TICK);
   localparam logic [7:0] L_DONE       = 8'(DONE_TICK);

   localparam logic [AW-1:0] L_TAP0 = TAP0_ADDR[AW-1:0];
   localparam logic [AW-1:0] L_TAP1 = TAP1_ADDR[AW-1:0];

   localparam bit L_PARAMS_OK = (READ_TICK > 0) &&
                                (READ_TICK < STROBE_START) &&
                                (STROBE_START + STROBE_LEN <= WRITE_TICK) &&
                                (WRITE_TICK < DONE_TICK) &&
                                (DONE_TICK <= 255);

   // Cycle phase: idle (timer 0), running (1..DONE_TICK-1), parked at done.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   // Control registers
   state_t        r_state;
   logic [7:0]    r_timer;
   logic          r_start_prev;
   logic          r_busy;
   logic          r_strobe_n;
   logic          r_done_n;
   logic [AW-1:0] r_addr;
   logic          r_wr_mode;

   // Datapath registers
   logic [DW-1:0] r_data_out;
   logic [DW-1:0] r_rbuf;
   logic [MW-1:0] r_mem [0:DEPTH-1];

   // Combinational next-state / datapath signals
   logic          w_start_edge;
   logic          w_accept;
   logic [7:0]    w_timer_nxt;
   state_t        w_state_nxt;
   logic          w_do_read;
   logic          w_do_write;
   logic [MW-1:0] w_rd_word;
   logic [MW-1:0] w_wr_word;

   // A start edge is a low-to-high transition of mem_start; it is only
   // honoured when no cycle is running (idle or parked at done).
   assign w_start_edge = bus.mem_start & ~r_start_prev;
   assign w_accept     = w_start_edge & (~r_busy | (r_timer == L_DONE));

   // Next timer/state: restart on accept, count while running, else hold.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
      w_timer_nxt = r_timer;
      w_state_nxt = r_state;
      if (w_accept) begin
         w_timer_nxt = 8'd1;
         w_state_nxt = ST_RUN;
      end else if (r_state == ST_RUN) begin
         w_timer_nxt = r_timer + 8'd1;
         if (w_timer_nxt == L_DONE) begin
            w_state_nxt = ST_DONE;
         end
      end
   end

   // Cycle controller: timer, phase, latched request and registered status
   // outputs, all derived from the next timer value so they line up with it.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_timer      <= 8'd0;
         r_start_prev <= 1'b1;
         r_busy       <= 1'b0;
         r_strobe_n   <= 1'b1;
         r_done_n     <= 1'b1;
         r_addr       <= '0;
         r_wr_mode    <= 1'b0;
      end else begin
         r_start_prev <= bus.mem_start;
         r_state      <= w_state_nxt;
         r_timer      <= w_timer_nxt;
         r_busy       <= (w_state_nxt == ST_RUN);
         r_strobe_n   <= ~((w_timer_nxt >= L_STROBE_BEG) && (w_timer_nxt < L_STROBE_END));
         r_done_n     <= (w_state_nxt != ST_DONE);
         if (w_accept) begin
            r_addr    <= bus.addr;
            r_wr_mode <= bus.wr_mode;
         end
      end
   end

   // The timer passes each tick once per cycle, so these fire exactly once;
   // a reset clears the timer and therefore suppresses a pending write.
   assign w_do_read  = (r_timer == L_READ);
   assign w_do_write = (r_timer == L_WRITE);

   assign w_rd_word = r_mem[r_addr];

`ifdef MEM_PARITY_EN
   logic r_rbuf_par;
   logic r_parity_err;

   // Fresh data gets odd parity; a read-restore puts back the parity bit
   // exactly as it was read, so a corrupted bit stays detectable.
   assign w_wr_word = r_wr_mode ? {~^bus.data_in, bus.data_in} : {r_rbuf_par, r_rbuf};

   // Capture the stored parity bit and flag any even-parity word (sticky).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rbuf_par   <= 1'b0;
         r_parity_err <= 1'b0;
      end else if (w_do_read) begin
         r_rbuf_par <= w_rd_word[DW];
         if (^w_rd_word == 1'b0) begin
            r_parity_err <= 1'b1;
         end
      end
   end

   assign bus.parity_err = r_parity_err;
`else
   assign w_wr_word      = r_wr_mode ? bus.data_in : r_rbuf;
   assign bus.parity_err = 1'b0;
`endif

   // Read stage: load the addressed word into data_out and the read buffer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data_out <= '0;
         r_rbuf     <= '0;
      end else if (w_do_read) begin
         r_data_out <= w_rd_word[DW-1:0];
         r_rbuf     <= w_rd_word[DW-1:0];
      end
   end

   // Write-back stage: one write per cycle at WRITE_TICK.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; its contents survive reset and it maps onto plain RAM.
      if (w_do_write) begin
         r_mem[r_addr] <= w_wr_word;
      end
   end

   assign bus.data_out   = r_data_out;
   assign bus.strobe_n   = r_strobe_n;
   assign bus.mem_done_n = r_done_n;
   assign bus.busy       = r_busy;
   assign bus.tap0       = r_mem[L_TAP0][DW-1:0];
   assign bus.tap1       = r_mem[L_TAP1][DW-1:0];

`ifndef SYNTHESIS
   // Illegal timing parameters stop the simulation on the first clock.
   always_ff @(posedge clk) begin
      if (!L_PARAMS_OK) begin
         $fatal(1, "mem_core_timed: illegal timing parameters");
      end
   end
`endif

endmodule
